// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer: one LFSR-animated dice roll per button press, with lockout.
// Optional roll counter is built when DICE_ROLL_COUNT_EN is defined.
module dice_roll_sequencer #(
  parameter int ROLL_CYCLES = 16,
  parameter int ANIM_DIV    = 4,
  parameter int HOLD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic [2:0] lfsr_val,
  output logic       lfsr_en,
  output logic [2:0] disp_val,
  output logic       rolling,
  output logic       result_valid,
  output logic [7:0] roll_count
);
  localparam int RW = ROLL_CYCLES > 1 ? $clog2(ROLL_CYCLES) : 1;
  localparam int AW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RW-1:0] RLAST = RW'(ROLL_CYCLES - 1);
  localparam logic [AW-1:0] ALAST = AW'(ANIM_DIV - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ROLL, HOLD} state_e;
  state_e        state_q;
  logic          btn_q;
  logic          armed_q;
  logic [RW-1:0] rcnt_q;
  logic [AW-1:0] acnt_q;
  logic [HW-1:0] hcnt_q;
  logic [2:0]    disp_q;
  logic          valid_q;
  logic          press;
  logic          face_ok;
  logic          fin;
  // armed_q masks the first sample after reset so a button already held is not seen as an edge
  assign press   = btn & ~btn_q & armed_q;
  assign face_ok = lfsr_val != 3'd0 && lfsr_val != 3'd7;
  assign fin     = state_q == ROLL && rcnt_q >= RLAST && face_ok;
  assign lfsr_en      = state_q == ROLL;
  assign rolling      = state_q == ROLL;
  assign disp_val     = disp_q;
  assign result_valid = valid_q;
  // roll sequencing FSM: press edge -> animated roll -> latch face -> lockout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
      rcnt_q  <= '0;
      acnt_q  <= '0;
      hcnt_q  <= '0;
      disp_q  <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      btn_q   <= btn;
      armed_q <= 1'b1;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (press) begin
          state_q <= ROLL;
          rcnt_q  <= '0;
          acnt_q  <= '0;
        end
        ROLL: begin
          rcnt_q <= rcnt_q >= RLAST ? rcnt_q : rcnt_q + 1'b1;
          acnt_q <= acnt_q == ALAST ? '0 : acnt_q + 1'b1;
          if (acnt_q == ALAST && face_ok) disp_q <= lfsr_val;
          if (fin) begin
            disp_q  <= lfsr_val;
            valid_q <= 1'b1;
            state_q <= HOLD;
            hcnt_q  <= '0;
          end
        end
        HOLD: if (hcnt_q == HLAST) state_q <= IDLE;
              else hcnt_q <= hcnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef DICE_ROLL_COUNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  assign cnt_d      = cnt_q + 8'(cnt_q != 8'hff);
  assign roll_count = cnt_q;
  // completed-roll counter, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else if (fin) cnt_q <= cnt_d;
  end
`else
  assign roll_count = 8'd0;
`endif
endmodule

// File: tb/tb_dice_roll_sequencer.sv
// tb_dice_roll_sequencer: scoreboard bench for dice_roll_sequencer.
module tb_dice_roll_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic [2:0] lfsr_val = 3'd0;
  logic       lfsr_en;
  logic [2:0] disp_val;
  logic       rolling;
  logic       result_valid;
  logic [7:0] roll_count;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  typedef struct {logic [2:0] face; int at;} exp_t;
  exp_t sb[$];
  exp_t e;

  dice_roll_sequencer dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .lfsr_val(lfsr_val),
    .lfsr_en(lfsr_en), .disp_val(disp_val), .rolling(rolling),
    .result_valid(result_valid), .roll_count(roll_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] f, input int at);
    exp_t x;
    x.face = f;
    x.at = at;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!rst_n) exp_cnt = 0;
    else if (result_valid) begin
      if (sb.size() == 0) check("spurious_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("face", 32'(disp_val), 32'(e.face));
        check("valid_cycle", cyc, e.at);
        if (exp_cnt < 255) exp_cnt++;
`ifdef DICE_ROLL_COUNT_EN
        check("roll_count", 32'(roll_count), exp_cnt);
`else
        check("roll_count", 32'(roll_count), 0);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int edisp;
    step(2);
    check("rst_lfsr_en", 32'(lfsr_en), 0);
    check("rst_rolling", 32'(rolling), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_disp", 32'(disp_val), 0);
    check("rst_count", 32'(roll_count), 0);
    rst_n = 1'b1;
    step(3);
    // single press, constant face 3
    lfsr_val = 3'd3;
    t = cyc;
    push(3'd3, t + 17);
    btn = 1'b1;
    step();
    btn = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check("roll_en", 32'(lfsr_en), 1);
      check("roll_rolling", 32'(rolling), 1);
      step();
    end
    check("hold_en", 32'(lfsr_en), 0);
    check("hold_rolling", 32'(rolling), 0);
    step(31);
    check("hold_end_en", 32'(lfsr_en), 0);
    step();
    check("idle_disp", 32'(disp_val), 3);
    // animation: press accepted on first IDLE cycle, face steps 1..6
    t = cyc;
    edisp = 3;
    btn = 1'b1;
    step();
    btn = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check("anim_disp", 32'(disp_val), edisp);
      lfsr_val = 3'(((k - 1) % 6) + 1);
      if (k % 4 == 0) edisp = 32'(lfsr_val);
      if (k == 16) push(lfsr_val, t + 17);
      step();
    end
    step(32);
    check("anim_final_disp", 32'(disp_val), 4);
    // invalid final sample extends roll by one cycle
    t = cyc;
    lfsr_val = 3'd2;
    btn = 1'b1;
    step();
    btn = 1'b0;
    step(15);
    lfsr_val = 3'd7;
    push(3'd5, t + 18);
    step();
    check("ext_en", 32'(lfsr_en), 1);
    check("ext_disp", 32'(disp_val), 2);
    lfsr_val = 3'd5;
    step();
    check("ext_done_en", 32'(lfsr_en), 0);
    step(32);
    // lockout: edges in ROLL and HOLD ignored, held level never retriggers
    t = cyc;
    lfsr_val = 3'd6;
    push(3'd6, t + 17);
    btn = 1'b1;
    step();
    btn = 1'b0;
    step(4);
    btn = 1'b1;
    step();
    btn = 1'b0;
    step(14);
    btn = 1'b1;
    step(29);
    for (int k = 0; k < 12; k++) begin
      check("held_no_retrig", 32'(lfsr_en), 0);
      step();
    end
    btn = 1'b0;
    step();
    t = cyc;
    push(3'd6, t + 17);
    btn = 1'b1;
    step();
    btn = 1'b0;
    check("rearm_en", 32'(lfsr_en), 1);
    step(48);
    // asynchronous reset mid-roll
    lfsr_val = 3'd1;
    btn = 1'b1;
    step(8);
    rst_n = 1'b0;
    #1;
    check("async_en", 32'(lfsr_en), 0);
    check("async_disp", 32'(disp_val), 0);
    check("async_rolling", 32'(rolling), 0);
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("post_rst_no_roll", 32'(lfsr_en), 0);
    end
    btn = 1'b0;
    step();
    // 257 back-to-back rolls exercise counter saturation
    for (int i = 0; i < 257; i++) begin
      lfsr_val = 3'((i % 6) + 1);
      t = cyc;
      push(lfsr_val, t + 17);
      btn = 1'b1;
      step();
      btn = 1'b0;
      step(48);
    end
`ifdef DICE_ROLL_COUNT_EN
    check("final_count", 32'(roll_count), 255);
`else
    check("final_count", 32'(roll_count), 0);
`endif
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dice_roll_sequencer.md
# dice_roll_sequencer

Sequences one dice roll per button press between the debouncer and the LFSR/seven-segment path. It edge-detects the debounced button and enables the LFSR for a fixed roll window, animating the display. It then latches a final face in the range 1–6, pulses a valid strobe, and locks out new presses for a hold window before re-arming.

## Interface
- `ROLL_CYCLES`, 16: cycles the LFSR is enabled per roll. Must be ≥1.
- `ANIM_DIV`, 4: display refresh period during a roll, in cycles. Must be ≥1.
- `HOLD_CYCLES`, 32: lockout cycles after the result is latched. Must be ≥1.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `btn`  input  1  debounced button level.
- `lfsr_val`  input  3  current LFSR face value.
- `lfsr_en`  output  1  LFSR advance enable.
- `disp_val`  output  3  value to the seven-segment decoder.
- `rolling`  output  1  high while in ROLL.
- `result_valid`  output  1  one-cycle strobe when a final face is latched.
- `roll_count`  output  8  completed rolls; see Configuration.

## Operation
- Button handling:
  - `btn` is registered once into `btn_q`.
  - Press edge = `btn & ~btn_q`.
  - Only an edge is a trigger. A held level never retriggers.
- States: IDLE, ROLL, HOLD.
- IDLE:
  - `lfsr_en`=0, `rolling`=0, `disp_val` holds the last result.
  - A press edge goes to ROLL. The roll counter and animation counter are cleared to 0.
- ROLL:
  - `lfsr_en`=1, `rolling`=1.
  - The roll counter increments each cycle. The animation counter wraps at ANIM_DIV-1.
  - When the animation counter equals ANIM_DIV-1 and `lfsr_val` is in 1..6, `disp_val` ← `lfsr_val`.
  - On the cycle the roll counter reaches ROLL_CYCLES-1 or beyond:
    - If `lfsr_val` is in 1..6: latch it into `disp_val`, set `result_valid` next cycle, go to HOLD, clear the hold counter.
    - If `lfsr_val` is 0 or 7: stay in ROLL one more cycle and re-test. The roll counter saturates and does not wrap.
- HOLD:
  - `lfsr_en`=0, `rolling`=0.
  - Press edges are ignored.
  - After HOLD_CYCLES cycles, go to IDLE.
- Press edges during ROLL or HOLD are discarded, not queued.
- Widths:
  - Counters are sized `$clog2(param)`, minimum 1 bit.
  - `disp_val` only ever takes values 0 (after reset) or 1..6.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - state=IDLE
  - `btn_q`=0
  - `lfsr_en`=0
  - `rolling`=0
  - `result_valid`=0
  - `disp_val`=3'd0 (blank)
  - `roll_count`=0
  - all counters 0
- Reset asserted mid-roll or mid-hold aborts immediately to the reset values.
- After `rst_n` rises, `btn` already high does not trigger. `btn_q` must see 1 first, so no edge is generated.
- Edge at cycle T (`btn`=1 at T, `btn_q`=0): state=ROLL and `lfsr_en`=1 from cycle T+1.
- With valid values, ROLL occupies cycles T+1 .. T+ROLL_CYCLES.
- At T+ROLL_CYCLES+1:
  - state=HOLD
  - `disp_val`=final face
  - `result_valid`=1 for exactly this cycle
  - `roll_count` updated
- HOLD covers T+ROLL_CYCLES+1 .. T+ROLL_CYCLES+HOLD_CYCLES.
- IDLE from T+ROLL_CYCLES+HOLD_CYCLES+1. A new edge is accepted that cycle.
- `lfsr_en` and `rolling` are decoded from the registered state; no input-to-output combinational path.
- `result_valid` and `disp_val` are registered.

## Configuration
- `DICE_ROLL_COUNT_EN`:
  - Defined: `roll_count` increments by 1 on each `result_valid` cycle and saturates at 255.
  - Undefined: `roll_count` is tied to 8'd0 and the counter logic is not built.
  - All other behaviour is identical either way.

## Test plan
- Reset, then one press: `btn` 0→1 at T with `lfsr_val`=3 constant.
  - Expect `lfsr_en` high T+1..T+16.
  - Expect `result_valid`=1 only at T+17 with `disp_val`=3.
  - Expect IDLE at T+49 (defaults).
- Animation: `lfsr_val` stepping 1..6 each cycle during ROLL.
  - Expect `disp_val` to change only every 4th ROLL cycle.
  - Expect the final value to equal `lfsr_val` at the last ROLL cycle.
- Invalid final sample: `lfsr_val`=7 at the last ROLL cycle, then 5.
  - Expect ROLL extended by exactly one cycle.
  - Expect the latched value to be 5, with `result_valid` one cycle later than nominal.
- Lockout: press edges at T+5 (ROLL) and T+20 (HOLD).
  - Expect no restart and no second `result_valid`.
  - With `btn` held high into IDLE, expect no retrigger until a 0→1 transition.
- Async reset mid-ROLL (`rst_n` low at T+8).
  - Expect `lfsr_en`=0 and `disp_val`=0 immediately, without waiting for a clock edge.
  - After release with `btn` high, expect no roll.
- `DICE_ROLL_COUNT_EN`:
  - Defined: 257 completed rolls give `roll_count`=255.
  - Undefined: `roll_count` stays 0 throughout.
